// File: rtl/gate_truth_checker.sv
// Truth-table sequencer: walks every input vector of a small gate under test,
// samples its output after a settle interval and reports a pass/fail summary.
module gate_truth_checker #(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        gate_sel,
    input  logic              y_in,
    output logic [N_IN-1:0]   vec_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [N_IN-1:0]   first_fail_vec,
    output logic              first_fail_valid,
    output logic              illegal_sel
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [N_IN-1:0]  VEC_LAST = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    localparam logic [2:0] SEL_AND  = 3'd0;
    localparam logic [2:0] SEL_OR   = 3'd1;
    localparam logic [2:0] SEL_XOR  = 3'd2;
    localparam logic [2:0] SEL_NAND = 3'd3;
    localparam logic [2:0] SEL_NOR  = 3'd4;
    localparam logic [2:0] SEL_XNOR = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2
    } state_e;

    localparam state_e FIRST_STATE = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;

    function automatic logic sel_legal(input logic [2:0] sel);
        return sel <= SEL_XNOR;
    endfunction

    function automatic logic expected_bit(input logic [2:0] sel, input logic [N_IN-1:0] vec);
        case (sel)
            SEL_AND:  return  (&vec);
            SEL_OR:   return  (|vec);
            SEL_XOR:  return  (^vec);
            SEL_NAND: return ~(&vec);
            SEL_NOR:  return ~(|vec);
            SEL_XNOR: return ~(^vec);
            default:  return 1'b0;
        endcase
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_IN-1:0]    vec_q, vec_d;
    logic [2:0]         sel_q, sel_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [N_IN-1:0]    ff_vec_q, ff_vec_d;
    logic               ff_valid_q, ff_valid_d;
    logic               illegal_q, illegal_d;
    // finish_q marks the cycle after a run ends; done and pass are issued from it.
    logic               finish_q, finish_d;
    // clr_q defers the result clear when a new run is accepted on the done edge.
    logic               clr_q, clr_d;

    logic               expected;
    logic               mismatch;
    logic [ERR_W-1:0]   err_b;
    logic [N_IN-1:0]    ff_vec_b;
    logic               ff_valid_b;
    logic               pass_b;
    logic               illegal_b;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        err_b      = clr_q ? '0   : err_q;
        ff_vec_b   = clr_q ? '0   : ff_vec_q;
        ff_valid_b = clr_q ? 1'b0 : ff_valid_q;
        pass_b     = clr_q ? 1'b0 : pass_q;
        illegal_b  = clr_q ? 1'b0 : illegal_q;

        // X/Z on y_in counts as a mismatch in simulation; synthesis reads this as !=.
        expected = expected_bit(sel_q, vec_q);
        mismatch = (y_in !== expected);

        state_d    = state_q;
        cnt_d      = cnt_q;
        vec_d      = vec_q;
        sel_d      = sel_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_b;
        err_d      = err_b;
        ff_vec_d   = ff_vec_b;
        ff_valid_d = ff_valid_b;
        illegal_d  = illegal_b;
        finish_d   = 1'b0;
        clr_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (finish_q) begin
                    done_d    = 1'b1;
                    vec_d     = '0;
                    illegal_d = ~sel_legal(sel_q);
                    pass_d    = sel_legal(sel_q) && (err_b == '0);
                end
                if (start) begin
                    sel_d = gate_sel;
                    vec_d = '0;
                    cnt_d = '0;
                    if (finish_q) begin
                        clr_d = 1'b1;
                    end else begin
                        err_d      = '0;
                        ff_vec_d   = '0;
                        ff_valid_d = 1'b0;
                        pass_d     = 1'b0;
                        illegal_d  = 1'b0;
                    end
                    if (sel_legal(gate_sel)) begin
                        busy_d  = 1'b1;
                        state_d = FIRST_STATE;
                    end else begin
                        finish_d = 1'b1;
                    end
                end
            end

            S_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_SAMPLE: begin
                if (mismatch) begin
                    if (err_b != ERR_MAX) begin
                        err_d = err_b + ERR_W'(1);
                    end
                    if (!ff_valid_b) begin
                        ff_vec_d   = vec_q;
                        ff_valid_d = 1'b1;
                    end
                end
                if (vec_q == VEC_LAST) begin
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                    finish_d = 1'b1;
                end else begin
                    vec_d   = vec_q + N_IN'(1);
                    cnt_d   = '0;
                    state_d = FIRST_STATE;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            vec_q      <= '0;
            sel_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            ff_vec_q   <= '0;
            ff_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
            finish_q   <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vec_q      <= vec_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            ff_vec_q   <= ff_vec_d;
            ff_valid_q <= ff_valid_d;
            illegal_q  <= illegal_d;
            finish_q   <= finish_d;
            clr_q      <= clr_d;
        end
    end

    assign vec_out          = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_vec   = ff_vec_q;
    assign first_fail_valid = ff_valid_q;
    assign illegal_sel      = illegal_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: a run-level timing model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_gate_truth_checker;

    localparam int S  = 2;
    localparam int NV = 4;
    localparam int L  = NV * (S + 1);

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start2;
    logic [2:0] gate_sel, gate_sel2;
    logic       y_in, y_in2;
    int         ymode;

    logic [1:0] vec_out, vec_out2;
    logic       busy, done, pass, ffv, ill;
    logic [7:0] err_count;
    logic [1:0] ffvec;
    logic       busy2, done2, pass2, ffv2, ill2;
    logic [1:0] err_count2;
    logic [1:0] ffvec2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic gate_fn(input int f, input int v);
        logic [1:0] bits;
        logic a, b;
        bits = v[1:0];
        a = bits[1];
        b = bits[0];
        case (f)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            3: return ~(a & b);
            4: return ~(a | b);
            5: return ~(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

    // Gates under test: dut1 sees a gate chosen by ymode, dut2 always sees XOR.
    assign y_in  = gate_fn(ymode, int'(vec_out));
    assign y_in2 = vec_out2[1] ^ vec_out2[0];

    gate_truth_checker #(.N_IN(2), .SETTLE_CYCLES(S), .ERR_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel), .y_in(y_in),
        .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail_vec(ffvec),
        .first_fail_valid(ffv), .illegal_sel(ill)
    );

    gate_truth_checker #(.N_IN(2), .SETTLE_CYCLES(S), .ERR_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .gate_sel(gate_sel2), .y_in(y_in2),
        .vec_out(vec_out2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err_count2), .first_fail_vec(ffvec2),
        .first_fail_valid(ffv2), .illegal_sel(ill2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Run-level model: a run is described by its accept cycle, and every output
    // follows from the cycle offset since acceptance.
    int  cyc = 0;
    bit  m_ready = 0, m_on = 0, m_legal = 0, m_clr = 0;
    int  m_k = 0, m_sel = 0, m_ymode = 0;
    bit  e_busy = 0, e_done = 0, e_pass = 0, e_ffv = 0, e_ill = 0;
    int  e_err = 0, e_ffvec = 0, e_vec = 0;

    always @(posedge clk) begin
        bit idle, fin;
        int t, v;
        cyc++;
        if (rst) begin
            m_ready = 1; m_on = 0; m_clr = 0;
            e_busy = 0; e_done = 0; e_pass = 0; e_ffv = 0; e_ill = 0;
            e_err = 0; e_ffvec = 0; e_vec = 0;
        end else begin
            t    = cyc - m_k;
            idle = !(m_on && m_legal && t <= L);
            fin  = m_on && (t == (m_legal ? L + 1 : 1));
            e_done = 0;
            if (m_clr) begin
                e_err = 0; e_ffv = 0; e_ffvec = 0; e_pass = 0; e_ill = 0; m_clr = 0;
            end
            if (m_on && m_legal && t >= 1 && t <= L && (t % (S + 1)) == 0) begin
                v = t / (S + 1) - 1;
                if (gate_fn(m_ymode, v) != gate_fn(m_sel, v)) begin
                    if (e_err < 255) e_err++;
                    if (!e_ffv) begin
                        e_ffv = 1;
                        e_ffvec = v;
                    end
                end
            end
            if (fin) begin
                e_done = 1;
                e_pass = m_legal && (e_err == 0);
                e_ill  = !m_legal;
                m_on   = 0;
            end
            if (start && idle) begin
                m_on = 1; m_k = cyc; m_sel = int'(gate_sel);
                m_legal = (gate_sel <= 3'd5); m_ymode = ymode;
                if (fin) m_clr = 1;
                else begin
                    e_err = 0; e_ffv = 0; e_ffvec = 0; e_pass = 0; e_ill = 0;
                end
            end
            t = cyc - m_k;
            e_busy = m_on && m_legal && (t < L);
            e_vec  = e_busy ? t / (S + 1) : 0;
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            check("m_busy", busy, e_busy);
            check("m_done", done, e_done);
            check("m_pass", pass, e_pass);
            check("m_err_count", err_count, e_err);
            check("m_first_fail_valid", ffv, e_ffv);
            check("m_first_fail_vec", ffvec, e_ffvec);
            check("m_illegal_sel", ill, e_ill);
            if (e_busy || !m_on) check("m_vec_out", vec_out, e_vec);
        end
    end

    task automatic at_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Pulse start for one cycle; k is the index of the accepting edge.
    task automatic pulse_start(input bit second, input logic [2:0] sel, output int k);
        @(negedge clk);
        if (second) begin start2 = 1'b1; gate_sel2 = sel; end
        else        begin start  = 1'b1; gate_sel  = sel; end
        @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
        k = cyc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, k2;
        int vec_tbl[12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        gate_sel = 3'd0; gate_sel2 = 3'd0; ymode = 0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_vec", vec_out, 2'd0);
        check("reset_err", err_count, 8'd0);
        rst = 1'b0;

        // 1: correct AND gate
        ymode = 0;
        pulse_start(1'b0, 3'd0, k);
        for (int t = 0; t < 12; t++) begin
            at_cycle(k + t);
            check("t1_busy", busy, 1'b1);
            check("t1_vec", vec_out, vec_tbl[t][1:0]);
        end
        at_cycle(k + 12);
        check("t1_busy_low", busy, 1'b0);
        check("t1_no_early_done", done, 1'b0);
        at_cycle(k + 13);
        check("t1_done", done, 1'b1);
        check("t1_pass", pass, 1'b1);
        check("t1_err", err_count, 8'd0);
        check("t1_ffv", ffv, 1'b0);
        at_cycle(k + 14);
        check("t1_done_pulse", done, 1'b0);
        check("t1_pass_hold", pass, 1'b1);

        // 2: AND expected, OR gate fitted
        ymode = 1;
        pulse_start(1'b0, 3'd0, k);
        at_cycle(k + 6);
        check("t2_err_mid", err_count, 8'd1);
        check("t2_ffvec_mid", ffvec, 2'd1);
        at_cycle(k + 13);
        check("t2_done", done, 1'b1);
        check("t2_err", err_count, 8'd2);
        check("t2_ffvec", ffvec, 2'd1);
        check("t2_ffv", ffv, 1'b1);
        check("t2_pass", pass, 1'b0);

        // 3: illegal selector
        pulse_start(1'b0, 3'd6, k);
        check("t3_busy", busy, 1'b0);
        at_cycle(k + 1);
        check("t3_done", done, 1'b1);
        check("t3_illegal", ill, 1'b1);
        check("t3_pass", pass, 1'b0);
        check("t3_err", err_count, 8'd0);
        check("t3_busy_after", busy, 1'b0);

        // 4: XOR, ignored mid-run start, back-to-back start on the done edge
        at_cycle(k + 4);
        ymode = 2;
        pulse_start(1'b0, 3'd2, k);
        at_cycle(k + 4);
        start = 1'b1; gate_sel = 3'd4;
        at_cycle(k + 5);
        start = 1'b0;
        check("t4_busy_ign", busy, 1'b1);
        at_cycle(k + 12);
        start = 1'b1; gate_sel = 3'd2;
        at_cycle(k + 13);
        start = 1'b0;
        check("t4_done1", done, 1'b1);
        check("t4_pass1", pass, 1'b1);
        at_cycle(k + 14);
        check("t4_run2_busy", busy, 1'b1);
        check("t4_run2_err", err_count, 8'd0);
        check("t4_run2_ffv", ffv, 1'b0);
        at_cycle(k + 25);
        check("t4_no_early_done2", done, 1'b0);
        at_cycle(k + 26);
        check("t4_done2", done, 1'b1);
        check("t4_pass2", pass, 1'b1);

        // 5: reset in the middle of a failing run, then a clean run
        ymode = 1;
        pulse_start(1'b0, 3'd0, k);
        at_cycle(k + 6);
        check("t5_err_before_rst", err_count, 8'd1);
        rst = 1'b1;
        at_cycle(k + 7);
        rst = 1'b0;
        check("t5_busy", busy, 1'b0);
        check("t5_vec", vec_out, 2'd0);
        check("t5_err", err_count, 8'd0);
        check("t5_ffv", ffv, 1'b0);
        check("t5_pass", pass, 1'b0);
        for (int c = k + 8; c <= k + 15; c++) begin
            at_cycle(c);
            check("t5_no_done", done, 1'b0);
        end
        ymode = 0;
        pulse_start(1'b0, 3'd0, k2);
        at_cycle(k2 + 13);
        check("t5_done_new", done, 1'b1);
        check("t5_pass_new", pass, 1'b1);

        // 6: narrow counter saturates (XNOR expected, XOR fitted)
        pulse_start(1'b1, 3'd5, k);
        at_cycle(k + 6);
        check("t6_err_2", err_count2, 2'd2);
        at_cycle(k + 9);
        check("t6_err_3", err_count2, 2'd3);
        at_cycle(k + 13);
        check("t6_done", done2, 1'b1);
        check("t6_err_sat", err_count2, 2'd3);
        check("t6_ffvec", ffvec2, 2'd0);
        check("t6_ffv", ffv2, 1'b1);
        check("t6_pass", pass2, 1'b0);
        check("t6_illegal", ill2, 1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
- Self-checking truth-table sequencer for small combinational gates such as and_gate and its sibling 2-input gates.
- Sits in front of the gate under test and drives every input combination in ascending binary order on vec_out.
- Samples the gate output on y_in after a settle interval and compares it with the expected function chosen by gate_sel.
- Reports a pass/fail summary, so gate checks run as a clocked, reusable stage instead of hand-written delay sequences.

Parameters:
- N_IN, 2, number of gate inputs; the sequencer drives 2^N_IN vectors.
- SETTLE_CYCLES, 2, cycles each vector is held before the sampling cycle (≥0).
- ERR_W, 8, width of the mismatch counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a check run; accepted only in IDLE.
- gate_sel  in  3  expected function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; 6 and 7 illegal.
- y_in  in  1  output of the gate under test.
- vec_out  out  N_IN  input vector to the gate under test; for N_IN=2, a=vec_out[1] and b=vec_out[0].
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse at the end of a run.
- pass  out  1  run result: 1 means zero mismatches and a legal gate_sel.
- err_count  out  ERR_W  number of mismatching vectors; saturates at all-ones.
- first_fail_vec  out  N_IN  first vector that mismatched.
- first_fail_valid  out  1  first_fail_vec holds a valid value.
- illegal_sel  out  1  the last run was started with gate_sel 6 or 7.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it has priority over all other inputs.
- Reset values: every output is 0; state is IDLE.
- States: IDLE, SETTLE, SAMPLE.
- Start acceptance: start is accepted when state is IDLE and start=1 at a rising edge k. On acceptance:
  - gate_sel is latched.
  - err_count, first_fail_*, pass and illegal_sel are cleared.
  - vec_out is set to 0, and the settle counter is set to 0.
- Illegal gate_sel (6 or 7) at acceptance:
  - State stays IDLE and busy stays 0.
  - At edge k+1: done=1, illegal_sel=1, pass=0.
- Legal gate_sel at acceptance: state goes to SETTLE, busy=1.
- SETTLE: holds vec_out for SETTLE_CYCLES cycles, then moves to SAMPLE. If SETTLE_CYCLES=0, go straight to SAMPLE.
- SAMPLE (one cycle): compare y_in with expected = f(gate_sel, reduction over vec_out).
  - AND/OR/XOR are the reduction operators; NAND/NOR/XNOR are their inversions.
  - On mismatch: err_count increments, saturating at all-ones. If first_fail_valid=0, capture vec_out into first_fail_vec and set first_fail_valid=1.
  - If vec_out is all-ones: go to IDLE, and at the next edge done=1, busy=0, vec_out=0, and pass=1 if err_count==0 (counting this sample), else pass=0.
  - Otherwise: vec_out increments and the state returns to SETTLE.
- Vector hold time: each vector is presented for exactly SETTLE_CYCLES+1 cycles, with sampling in the last of those cycles.
- Run timing: done is high in the cycle beginning at edge k + 2^N_IN·(SETTLE_CYCLES+1) + 1. For the defaults this is k+13.
- Result hold: done is a single-cycle pulse. pass, err_count, first_fail_* and illegal_sel hold until the next accepted start or rst.
- start while busy=1: ignored, with no effect on the run.
- start in the cycle where done=1: the state is IDLE, so the start is accepted and runs go back-to-back.
- rst mid-run: all outputs return to reset values at that edge, no done pulse is produced, and the partial result is discarded.
- y_in of X or Z in simulation counts as a mismatch. The RTL compares with case inequality, guarded so synthesis sees a plain compare.

Test Plan:
1. Defaults, gate_sel=0, y_in driven by a correct AND of vec_out[1]&vec_out[0]; start at edge k.
   - Required: vec_out steps 0,1,2,3, each held 3 cycles; busy high for 12 cycles; done at k+13.
   - Required result: pass=1, err_count=0, first_fail_valid=0.
2. gate_sel=0, y_in driven by OR of the vector bits.
   - Required: mismatches at vectors 1 and 2; err_count=2, first_fail_vec=1, first_fail_valid=1, pass=0.
3. gate_sel=6, start.
   - Required: busy never rises; at k+1 done=1, illegal_sel=1, pass=0, err_count=0.
4. Start a correct XOR run (gate_sel=2), pulse start again at k+5, then assert start in the done cycle.
   - Required: the k+5 start is ignored and the first done is still at k+13.
   - Required: the second run begins with cleared results and its done is at k+26.
5. Assert rst for one cycle at k+7 during a run.
   - Required: the next cycle shows busy=0, vec_out=0, all results 0, and no done pulse.
   - Required: a new start afterwards completes normally with pass=1.
6. ERR_W=2, gate_sel=5 (XNOR), y_in = XOR (always wrong).
   - Required: 4 mismatches, err_count saturates at 3, first_fail_vec=0, pass=0.
